// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and port indices.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic PCpu = 1'b0;
  localparam logic PDma = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way request picker: single request wins outright; ties resolved by fixed priority
// (port 0) or by alternating away from the last granted port.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt,
  output logic       valid
);
  import dmem_arbiter_pkg::*;

  always_comb begin
    valid = |req;
    gnt   = PCpu;
    case (req)
      2'b10:   gnt = PDma;
      2'b11:   gnt = fixed ? PCpu : ~last;
      default: gnt = PCpu;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two req/ack requesters onto a single-port data memory; one transaction per
// IDLE -> ACCESS -> RESP pass, with read data returned from a register in RESP.
module dmem_arbiter #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned AW         = 10,
  parameter int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  import dmem_arbiter_pkg::*;

  state_e        r_state, w_state_next;
  logic          r_gnt, r_we, r_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rd;
  logic          w_gnt, w_valid, w_latch;
  logic [DW-1:0] w_resp_data;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .last  (r_last),
    .fixed (FIXED_PRIO),
    .gnt   (w_gnt),
    .valid (w_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= PCpu;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_last  <= PDma;
    end else begin
      if (w_latch) begin
        r_gnt   <= w_gnt;
        r_we    <= w_gnt ? we1 : we0;
        r_addr  <= w_gnt ? addr1 : addr0;
        r_wdata <= w_gnt ? wdata1 : wdata0;
        r_last  <= w_gnt;
      end
      if (r_state == StAccess && !r_we) begin
        r_rd <= mem_rdata;
      end
    end
  end

  // Write transactions hand back zero rather than stale read data.
  assign w_resp_data = r_we ? '0 : r_rd;

  // All memory strobes and acks come from registered state only, so a reset drops them at once.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    rdata0       = '0;
    rdata1       = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    busy         = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_valid) begin
          w_latch      = 1'b1;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        busy         = 1'b1;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        mem_wr       = r_we;
        mem_rd       = ~r_we;
        w_state_next = StResp;
      end
      StResp: begin
        busy         = 1'b1;
        w_state_next = StIdle;
        if (r_gnt == PDma) begin
          ack1   = 1'b1;
          rdata1 = w_resp_data;
        end else begin
          ack0   = 1'b1;
          rdata0 = w_resp_data;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule
